// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_pkg
// Purpose : Shared widths, default moduli and the packed BCD digit record
//           used by the stopwatch counter chain and its BCD converters.
// Rev     : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

    localparam int CNT_W   = 13;   // every time field is a 13-bit unsigned count
    localparam int DIGIT_W = 4;    // one BCD digit

    localparam int SMALL_MOD_DEF = 100;
    localparam int SEC_MOD_DEF   = 60;
    localparam int MIN_MOD_DEF   = 60;
    localparam int HR_MOD_DEF    = 24;

    typedef struct packed {
        logic [DIGIT_W-1:0] thousands;
        logic [DIGIT_W-1:0] hundreds;
        logic [DIGIT_W-1:0] tens;
        logic [DIGIT_W-1:0] ones;
    } bcd4_t;

endpackage
`default_nettype wire

// File: rtl/bin13_to_bcd4.sv
`default_nettype none
// ============================================================================
// Module  : bin13_to_bcd4
// Purpose : Combinational 13-bit binary to 4-digit BCD converter
//           (double-dabble, 13 shift iterations).
// Ports   : A         in  13  binary value 0..8191
//           ONES      out  4  ones digit (0..9)
//           TENS      out  4  tens digit (0..9)
//           HUNDREDS  out  4  hundreds digit (0..9)
//           thousands out  4  thousands digit (0..8)
// Rev     : 1.0  initial release
// ============================================================================
module bin13_to_bcd4
    import stopwatch_pkg::*;
(
    input  logic [CNT_W-1:0]   A,
    output logic [DIGIT_W-1:0] ONES,
    output logic [DIGIT_W-1:0] TENS,
    output logic [DIGIT_W-1:0] HUNDREDS,
    output logic [DIGIT_W-1:0] thousands
);

    localparam int c_BCD_W = 4 * DIGIT_W;

    // {bcd digits, binary}; the binary part is shifted up into the digits.
    logic [c_BCD_W+CNT_W-1:0] w_shift;

    always_comb begin
        w_shift = {{c_BCD_W{1'b0}}, A};
        for (int i = 0; i < CNT_W; i++) begin
            // Pre-correct any digit >= 5 so the following doubling carries
            // correctly into the next decimal digit.
            for (int d = 0; d < 4; d++) begin
                if (w_shift[CNT_W + d*DIGIT_W +: DIGIT_W] >= 4'd5) begin
                    w_shift[CNT_W + d*DIGIT_W +: DIGIT_W] =
                        w_shift[CNT_W + d*DIGIT_W +: DIGIT_W] + 4'd3;
                end
            end
            w_shift = w_shift << 1;
        end
        ONES      = w_shift[CNT_W + 0*DIGIT_W +: DIGIT_W];
        TENS      = w_shift[CNT_W + 1*DIGIT_W +: DIGIT_W];
        HUNDREDS  = w_shift[CNT_W + 2*DIGIT_W +: DIGIT_W];
        thousands = w_shift[CNT_W + 3*DIGIT_W +: DIGIT_W];
    end

endmodule
`default_nettype wire

// File: rtl/stopwatch_bcd.sv
`default_nettype none
// ============================================================================
// Module  : stopwatch_bcd
// Purpose : Free-running elapsed-time counter (centiseconds, seconds,
//           minutes, hours) with a prescaler and BCD views of every field.
// Ports   : clk            in   1  system clock, rising edge
//           reset          in   1  synchronous active-high reset
//           small_sec_out  out 13  centisecond count (binary)
//           seconds_out    out 13  seconds count (binary)
//           minutes_out    out 13  minutes count (binary)
//           hours_out      out 13  hours count (binary)
//           small_bcd      out 16  {thousands,hundreds,tens,ones} of small_sec_out
//           sec_bcd        out 16  BCD of seconds_out
//           min_bcd        out 16  BCD of minutes_out
//           hr_bcd         out 16  BCD of hours_out
// Rev     : 1.0  initial release
// ============================================================================
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 1,
    parameter int SMALL_MOD = SMALL_MOD_DEF,
    parameter int SEC_MOD   = SEC_MOD_DEF,
    parameter int MIN_MOD   = MIN_MOD_DEF,
    parameter int HR_MOD    = HR_MOD_DEF
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] small_sec_out,
    output logic [CNT_W-1:0] seconds_out,
    output logic [CNT_W-1:0] minutes_out,
    output logic [CNT_W-1:0] hours_out,
    output logic [15:0]      small_bcd,
    output logic [15:0]      sec_bcd,
    output logic [15:0]      min_bcd,
    output logic [15:0]      hr_bcd
);

    localparam int c_DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_TICK_LAST  = c_DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   c_SMALL_LAST = CNT_W'(SMALL_MOD - 1);
    localparam logic [CNT_W-1:0]   c_SEC_LAST   = CNT_W'(SEC_MOD - 1);
    localparam logic [CNT_W-1:0]   c_MIN_LAST   = CNT_W'(MIN_MOD - 1);
    localparam logic [CNT_W-1:0]   c_HR_LAST    = CNT_W'(HR_MOD - 1);

    logic [c_DIV_W-1:0] r_presc_q, w_presc_d;
    logic [CNT_W-1:0]   r_small_q, w_small_d;
    logic [CNT_W-1:0]   r_sec_q,   w_sec_d;
    logic [CNT_W-1:0]   r_min_q,   w_min_d;
    logic [CNT_W-1:0]   r_hr_q,    w_hr_d;

    logic w_tick;
    logic w_small_wrap;
    logic w_sec_wrap;
    logic w_min_wrap;

    // Carries are qualified by every lower stage so a full rollover
    // (e.g. x:59:59.99 -> x+1:00:00.00) completes in a single edge.
    always_comb begin
        w_tick       = (r_presc_q == c_TICK_LAST);
        w_small_wrap = w_tick       && (r_small_q == c_SMALL_LAST);
        w_sec_wrap   = w_small_wrap && (r_sec_q   == c_SEC_LAST);
        w_min_wrap   = w_sec_wrap   && (r_min_q   == c_MIN_LAST);

        w_presc_d = w_tick ? '0 : r_presc_q + c_DIV_W'(1);

        w_small_d = r_small_q;
        if (w_tick) begin
            w_small_d = w_small_wrap ? '0 : r_small_q + CNT_W'(1);
        end

        w_sec_d = r_sec_q;
        if (w_small_wrap) begin
            w_sec_d = w_sec_wrap ? '0 : r_sec_q + CNT_W'(1);
        end

        w_min_d = r_min_q;
        if (w_sec_wrap) begin
            w_min_d = w_min_wrap ? '0 : r_min_q + CNT_W'(1);
        end

        w_hr_d = r_hr_q;
        if (w_min_wrap) begin
            w_hr_d = (r_hr_q == c_HR_LAST) ? '0 : r_hr_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc_q <= '0;
            r_small_q <= '0;
            r_sec_q   <= '0;
            r_min_q   <= '0;
            r_hr_q    <= '0;
        end else begin
            r_presc_q <= w_presc_d;
            r_small_q <= w_small_d;
            r_sec_q   <= w_sec_d;
            r_min_q   <= w_min_d;
            r_hr_q    <= w_hr_d;
        end
    end

    assign small_sec_out = r_small_q;
    assign seconds_out   = r_sec_q;
    assign minutes_out   = r_min_q;
    assign hours_out     = r_hr_q;

    // BCD views: index 0 = small_sec, 1 = seconds, 2 = minutes, 3 = hours.
    logic [CNT_W-1:0]   w_bin [4];
    logic [DIGIT_W-1:0] w_on  [4];
    logic [DIGIT_W-1:0] w_te  [4];
    logic [DIGIT_W-1:0] w_hu  [4];
    logic [DIGIT_W-1:0] w_th  [4];
    bcd4_t              w_bcd [4];

    assign w_bin[0] = r_small_q;
    assign w_bin[1] = r_sec_q;
    assign w_bin[2] = r_min_q;
    assign w_bin[3] = r_hr_q;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_conv
            bin13_to_bcd4 u_conv (
                .A         (w_bin[g]),
                .ONES      (w_on[g]),
                .TENS      (w_te[g]),
                .HUNDREDS  (w_hu[g]),
                .thousands (w_th[g])
            );
            assign w_bcd[g] = {w_th[g], w_hu[g], w_te[g], w_on[g]};
        end
    endgenerate

    assign small_bcd = w_bcd[0];
    assign sec_bcd   = w_bcd[1];
    assign min_bcd   = w_bcd[2];
    assign hr_bcd    = w_bcd[3];

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_bcd.sv
`default_nettype none
// ============================================================================
// Module  : tb_stopwatch_bcd
// Purpose : Directed self-checking bench for stopwatch_bcd and bin13_to_bcd4.
//           u_main : defaults, TICK_DIV=1
//           u_div4 : TICK_DIV=4
//           u_hr2  : MIN_MOD=2, HR_MOD=2 (full rollover after 24000 ticks)
// Rev     : 1.0  initial release
// ============================================================================
module tb_stopwatch_bcd;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic r_rst_main, r_rst_div4, r_rst_hr2;

    logic [12:0] w_m_small, w_m_sec, w_m_min, w_m_hr;
    logic [15:0] w_m_sbcd, w_m_secbcd, w_m_minbcd, w_m_hrbcd;
    logic [12:0] w_d_small, w_d_sec, w_d_min, w_d_hr;
    logic [15:0] w_d_sbcd, w_d_secbcd, w_d_minbcd, w_d_hrbcd;
    logic [12:0] w_h_small, w_h_sec, w_h_min, w_h_hr;
    logic [15:0] w_h_sbcd, w_h_secbcd, w_h_minbcd, w_h_hrbcd;

    logic [12:0] r_conv_a;
    logic [3:0]  w_c_on, w_c_te, w_c_hu, w_c_th;

    stopwatch_bcd u_main (
        .clk(clk), .reset(r_rst_main),
        .small_sec_out(w_m_small), .seconds_out(w_m_sec),
        .minutes_out(w_m_min), .hours_out(w_m_hr),
        .small_bcd(w_m_sbcd), .sec_bcd(w_m_secbcd),
        .min_bcd(w_m_minbcd), .hr_bcd(w_m_hrbcd)
    );

    stopwatch_bcd #(.TICK_DIV(4)) u_div4 (
        .clk(clk), .reset(r_rst_div4),
        .small_sec_out(w_d_small), .seconds_out(w_d_sec),
        .minutes_out(w_d_min), .hours_out(w_d_hr),
        .small_bcd(w_d_sbcd), .sec_bcd(w_d_secbcd),
        .min_bcd(w_d_minbcd), .hr_bcd(w_d_hrbcd)
    );

    stopwatch_bcd #(.MIN_MOD(2), .HR_MOD(2)) u_hr2 (
        .clk(clk), .reset(r_rst_hr2),
        .small_sec_out(w_h_small), .seconds_out(w_h_sec),
        .minutes_out(w_h_min), .hours_out(w_h_hr),
        .small_bcd(w_h_sbcd), .sec_bcd(w_h_secbcd),
        .min_bcd(w_h_minbcd), .hr_bcd(w_h_hrbcd)
    );

    bin13_to_bcd4 u_conv (
        .A(r_conv_a), .ONES(w_c_on), .TENS(w_c_te),
        .HUNDREDS(w_c_hu), .thousands(w_c_th)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int r_t      = 0;   // edges since reset release

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h expected 'h%0h (t=%0d)", tag, got, exp, r_t);
        end
    endtask

    // Advance to just after edge number 'target' counted from reset release.
    task automatic advance(input int target);
        while (r_t < target) begin
            @(posedge clk);
            #1;
            r_t++;
        end
    endtask

    task automatic check_main(input string tag, input int hr, input int mn,
                              input int sc, input int sm);
        check({tag, ".small"}, 32'(w_m_small), 32'(sm));
        check({tag, ".sec"},   32'(w_m_sec),   32'(sc));
        check({tag, ".min"},   32'(w_m_min),   32'(mn));
        check({tag, ".hr"},    32'(w_m_hr),    32'(hr));
    endtask

    initial begin
        r_rst_main = 1'b1;
        r_rst_div4 = 1'b1;
        r_rst_hr2  = 1'b1;
        r_conv_a   = '0;

        repeat (5) @(posedge clk);
        #1;
        check_main("rst", 0, 0, 0, 0);
        check("rst.sbcd",   32'(w_m_sbcd),   32'h0000);
        check("rst.secbcd", 32'(w_m_secbcd), 32'h0000);
        check("rst.minbcd", 32'(w_m_minbcd), 32'h0000);
        check("rst.hrbcd",  32'(w_m_hrbcd),  32'h0000);
        check("rst.div4",   32'(w_d_small),  32'd0);
        check("rst.hr2",    32'(w_h_small),  32'd0);

        r_rst_main = 1'b0;
        r_rst_div4 = 1'b0;
        r_rst_hr2  = 1'b0;

        advance(1);
        check("start1", 32'(w_m_small), 32'd1);
        check("start1.bcd", 32'(w_m_sbcd), 32'h0001);
        advance(2);
        check("start2", 32'(w_m_small), 32'd2);
        check("start2.bcd", 32'(w_m_sbcd), 32'h0002);
        advance(3);
        check("start3", 32'(w_m_small), 32'd3);
        check("start3.bcd", 32'(w_m_sbcd), 32'h0003);
        check("div4.t3", 32'(w_d_small), 32'd0);
        advance(4);
        check("div4.t4", 32'(w_d_small), 32'd1);
        advance(7);
        check("div4.t7", 32'(w_d_small), 32'd1);
        advance(8);
        check("div4.t8", 32'(w_d_small), 32'd2);

        advance(100);
        check_main("carry100", 0, 0, 1, 0);
        check("carry100.secbcd", 32'(w_m_secbcd), 32'h0001);
        check("carry100.sbcd",   32'(w_m_sbcd),   32'h0000);

        // 0:00:03.47, then a one-cycle reset on u_main and u_div4.
        advance(347);
        check_main("pre_rst", 0, 0, 3, 47);
        check("pre_rst.sbcd", 32'(w_m_sbcd), 32'h0047);
        check("pre_rst.div4", 32'(w_d_small), 32'd86);
        r_rst_main = 1'b1;
        r_rst_div4 = 1'b1;
        advance(348);
        check_main("mid_rst", 0, 0, 0, 0);
        check("mid_rst.sbcd",   32'(w_m_sbcd),   32'h0000);
        check("mid_rst.secbcd", 32'(w_m_secbcd), 32'h0000);
        check("mid_rst.div4",   32'(w_d_small),  32'd0);
        r_rst_main = 1'b0;
        r_rst_div4 = 1'b0;
        advance(349);
        check("restart1", 32'(w_m_small), 32'd1);
        advance(351);
        check("div4.presc_clr3", 32'(w_d_small), 32'd0);
        advance(352);
        check("div4.presc_clr4", 32'(w_d_small), 32'd1);

        // Minute carry: 6000 ticks after the mid-run reset.
        advance(6347);
        check_main("pre_min", 0, 0, 59, 99);
        check("pre_min.secbcd", 32'(w_m_secbcd), 32'h0059);
        check("pre_min.sbcd",   32'(w_m_sbcd),   32'h0099);
        advance(6348);
        check_main("min_carry", 0, 1, 0, 0);
        check("min_carry.minbcd", 32'(w_m_minbcd), 32'h0001);

        // Full rollover on u_hr2 after 2*2*60*100 = 24000 ticks.
        advance(23999);
        check("roll_pre.hr",  32'(w_h_hr),    32'd1);
        check("roll_pre.min", 32'(w_h_min),   32'd1);
        check("roll_pre.sec", 32'(w_h_sec),   32'd59);
        check("roll_pre.sm",  32'(w_h_small), 32'd99);
        check("roll_pre.hrbcd",  32'(w_h_hrbcd),  32'h0001);
        check("roll_pre.minbcd", 32'(w_h_minbcd), 32'h0001);
        check("roll_pre.secbcd", 32'(w_h_secbcd), 32'h0059);
        check("roll_pre.sbcd",   32'(w_h_sbcd),   32'h0099);
        advance(24000);
        check("roll.hr",  32'(w_h_hr),    32'd0);
        check("roll.min", 32'(w_h_min),   32'd0);
        check("roll.sec", 32'(w_h_sec),   32'd0);
        check("roll.sm",  32'(w_h_small), 32'd0);
        check("roll.hrbcd", 32'(w_h_hrbcd), 32'h0000);
        check("roll.sbcd",  32'(w_h_sbcd),  32'h0000);
        // u_main: 23652 ticks since its reset -> 0:03:56.52
        check_main("main24000", 0, 3, 56, 52);
        check("main24000.sbcd",   32'(w_m_sbcd),   32'h0052);
        check("main24000.secbcd", 32'(w_m_secbcd), 32'h0056);
        check("main24000.minbcd", 32'(w_m_minbcd), 32'h0003);

        // Converter spot values.
        r_conv_a = 13'd8191; #1;
        check("conv8191", 32'({w_c_th, w_c_hu, w_c_te, w_c_on}), 32'h8191);
        r_conv_a = 13'd1999; #1;
        check("conv1999", 32'({w_c_th, w_c_hu, w_c_te, w_c_on}), 32'h1999);
        r_conv_a = 13'd0; #1;
        check("conv0", 32'({w_c_th, w_c_hu, w_c_te, w_c_on}), 32'h0000);
        r_conv_a = 13'd59; #1;
        check("conv59", 32'({w_c_th, w_c_hu, w_c_te, w_c_on}), 32'h0059);

        // Exhaustive converter sweep against a divide/modulo model.
        for (int v = 0; v < 8192; v++) begin
            logic [15:0] exp_bcd;
            r_conv_a = 13'(v);
            exp_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            #1;
            check("conv_sweep", 32'({w_c_th, w_c_hu, w_c_te, w_c_on}), 32'(exp_bcd));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
